// File: rtl/reset_seq_pkg.sv
// -----------------------------------------------------------------------------
// reset_seq_pkg
//
// Shared definitions for the reset sequencer:
//   - reset_seq_state_t : sequencer FSM states (HOLD, STRETCH, RELEASE, RUN)
//   - *_MIN constants   : smallest legal value of each sequencer parameter
//   - cnt_width()       : counter width needed to hold a value, never below 1
// -----------------------------------------------------------------------------
package reset_seq_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } reset_seq_state_t;

  // Smallest legal parameter values.
  localparam int SYNC_STAGES_MIN    = 2;
  localparam int NUM_OUT_MIN        = 1;
  localparam int STRETCH_CYCLES_MIN = 0;
  localparam int STAGE_GAP_MIN      = 1;

  // Width of a counter that must hold 'value'. A value of 0 is treated as 1,
  // so the counter always has at least one bit.
  function automatic int cnt_width(input int value);
    int v;
    if (value < 1) begin
      v = 1;
    end else begin
      v = value;
    end
    return $clog2(v + 1);
  endfunction

endpackage

// File: rtl/reset_sync.sv
// -----------------------------------------------------------------------------
// reset_sync
//
// Preset-style reset synchroniser chain. Every stage is preset to 1 while
// async_reset_n is low, so assertion is immediate. After release, a 0 enters
// stage 0 and walks down the chain one stage per enabled clock edge, so
// rst_sync falls SYNC_STAGES enabled edges after release.
//
// Ports:
//   clk           in  : system clock
//   async_reset_n in  : asynchronous active-low reset (presets the chain)
//   clk_enable    in  : chain shifts only when high
//   rst_sync      out : synchronised active-high reset (last chain stage)
// -----------------------------------------------------------------------------
module reset_sync
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 4
) (
  input  logic clk,
  input  logic async_reset_n,
  input  logic clk_enable,
  output logic rst_sync
);

  // Reject a chain too short to be a synchroniser.
  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync_stages
    $error("reset_sync: SYNC_STAGES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] chain_d;
  logic [SYNC_STAGES-1:0] chain_q;

  // Next chain value: shift a 0 into stage 0 on enabled edges, else hold.
  always_comb begin
    chain_d = chain_q;
    if (clk_enable) begin
      chain_d = {chain_q[SYNC_STAGES-2:0], 1'b0};
    end else begin
      chain_d = chain_q;
    end
  end

  // Chain flops, preset asynchronously while the board reset is low.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      chain_q <= '1;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign rst_sync = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_seq.sv
// -----------------------------------------------------------------------------
// reset_seq
//
// Reset sequencer for the 6502 system. The board reset is synchronised to clk,
// held for STRETCH_CYCLES further enabled cycles, and then the NUM_OUT
// sequenced resets are released one at a time (bit 0 first), STAGE_GAP enabled
// cycles apart. reset_done rises on the edge the last bit is released.
//
// Ports:
//   clk            in            : system clock
//   async_reset_n  in            : asynchronous active-low board reset
//   clk_enable     in            : all sequential state advances only when high
//   soft_reset_req in            : synchronous active-high soft reset request
//                                  (only with RESET_SEQ_SOFT_REQ_EN defined)
//   sync_reset     out [NUM_OUT] : active-high resets, registered
//   reset_done     out           : high once every sync_reset bit is low
//
// Build option:
//   RESET_SEQ_SOFT_REQ_EN - adds soft_reset_req. A request seen in STRETCH,
//   RELEASE or RUN reasserts every output and parks the FSM in HOLD until the
//   request drops; the sequence then resumes from STRETCH without re-running
//   the synchroniser.
// -----------------------------------------------------------------------------
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 4,
  parameter int NUM_OUT        = 3,
  parameter int STRETCH_CYCLES = 16,
  parameter int STAGE_GAP      = 4
) (
  input  logic               clk,
  input  logic               async_reset_n,
  input  logic               clk_enable,
`ifdef RESET_SEQ_SOFT_REQ_EN
  input  logic               soft_reset_req,
`endif
  output logic [NUM_OUT-1:0] sync_reset,
  output logic               reset_done
);

  // ---------------------------------------------------------------------------
  // Parameter legality (SYNC_STAGES is checked inside reset_sync)
  // ---------------------------------------------------------------------------
  if (NUM_OUT < NUM_OUT_MIN) begin : g_bad_num_out
    $error("reset_seq: NUM_OUT must be at least 1");
  end
  if (STRETCH_CYCLES < STRETCH_CYCLES_MIN) begin : g_bad_stretch
    $error("reset_seq: STRETCH_CYCLES must not be negative");
  end
  if (STAGE_GAP < STAGE_GAP_MIN) begin : g_bad_stage_gap
    $error("reset_seq: STAGE_GAP must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // Counter geometry
  // ---------------------------------------------------------------------------
  localparam int STR_W = cnt_width(STRETCH_CYCLES);
  localparam int GAP_W = cnt_width(STAGE_GAP);
  localparam int IDX_W = cnt_width(NUM_OUT - 1);

  // Last stretch count before release; only meaningful when STRETCH_CYCLES > 0.
  localparam int STR_LAST_I = (STRETCH_CYCLES > 0) ? (STRETCH_CYCLES - 1) : 0;

  localparam logic [STR_W-1:0] STR_LAST   = STR_W'(STR_LAST_I);
  localparam logic [STR_W-1:0] STR_ONE    = STR_W'(1);
  // The gap counter expires at 0, so loading GAP-1 spaces releases GAP edges.
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(STAGE_GAP - 1);
  localparam logic [GAP_W-1:0] GAP_ONE    = GAP_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_OUT - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic rst_sync_s;

  reset_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_reset_sync (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .clk_enable    (clk_enable),
    .rst_sync      (rst_sync_s)
  );

  // ---------------------------------------------------------------------------
  // Soft request (tied off when the option is not built)
  // ---------------------------------------------------------------------------
  logic soft_req_s;

`ifdef RESET_SEQ_SOFT_REQ_EN
  assign soft_req_s = soft_reset_req;
`else
  assign soft_req_s = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  reset_seq_state_t   state_d,      state_q;
  logic [STR_W-1:0]   str_cnt_d,    str_cnt_q;
  logic [GAP_W-1:0]   gap_cnt_d,    gap_cnt_q;
  logic [IDX_W-1:0]   idx_d,        idx_q;
  logic [NUM_OUT-1:0] sync_reset_d, sync_reset_q;
  logic               reset_done_d, reset_done_q;
  logic               enter_release_s;

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d         = state_q;
    str_cnt_d       = str_cnt_q;
    gap_cnt_d       = gap_cnt_q;
    idx_d           = idx_q;
    sync_reset_d    = sync_reset_q;
    reset_done_d    = reset_done_q;
    enter_release_s = 1'b0;

    if (!clk_enable) begin
      // Disabled cycle: everything freezes.
      state_d = state_q;
    end else if (soft_req_s && (state_q != HOLD)) begin
      // Soft request: reassert every output and park in HOLD.
      state_d      = HOLD;
      str_cnt_d    = '0;
      gap_cnt_d    = '0;
      idx_d        = '0;
      sync_reset_d = '1;
      reset_done_d = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          // The synchroniser has already released after a soft request,
          // so only the request itself keeps the FSM here in that case.
          if (!rst_sync_s && !soft_req_s) begin
            if (STRETCH_CYCLES == 0) begin
              enter_release_s = 1'b1;
            end else begin
              state_d   = STRETCH;
              str_cnt_d = '0;
            end
          end else begin
            state_d = HOLD;
          end
        end

        STRETCH: begin
          if (str_cnt_q >= STR_LAST) begin
            enter_release_s = 1'b1;
          end else begin
            str_cnt_d = str_cnt_q + STR_ONE;
          end
        end

        RELEASE: begin
          if (gap_cnt_q == '0) begin
            // Bits release in index order, so shifting the mask left clears
            // exactly the next bit and can never set one again.
            sync_reset_d = sync_reset_q << 1'b1;
            gap_cnt_d    = GAP_RELOAD;
            if (idx_q >= IDX_LAST) begin
              idx_d = idx_q;
            end else begin
              idx_d = idx_q + IDX_ONE;
            end
            if (idx_d >= IDX_LAST) begin
              state_d      = RUN;
              reset_done_d = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            gap_cnt_d = gap_cnt_q - GAP_ONE;
          end
        end

        RUN: begin
          state_d = RUN;
        end

        default: begin
          // Unreachable encoding: fall back to the safe, fully-reset state.
          state_d      = HOLD;
          str_cnt_d    = '0;
          gap_cnt_d    = '0;
          idx_d        = '0;
          sync_reset_d = '1;
          reset_done_d = 1'b0;
        end
      endcase

      // Release entry: the edge leaving the stretch also frees bit 0.
      if (enter_release_s) begin
        sync_reset_d = {NUM_OUT{1'b1}} << 1'b1;
        gap_cnt_d    = GAP_RELOAD;
        idx_d        = '0;
        if (NUM_OUT == 1) begin
          state_d      = RUN;
          reset_done_d = 1'b1;
        end else begin
          state_d = RELEASE;
        end
      end else begin
        enter_release_s = 1'b0;
      end
    end
  end

  // Sequencer flops; the board reset forces the full reset state at once.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q      <= HOLD;
      str_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      idx_q        <= '0;
      sync_reset_q <= '1;
      reset_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      str_cnt_q    <= str_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      idx_q        <= idx_d;
      sync_reset_q <= sync_reset_d;
      reset_done_q <= reset_done_d;
    end
  end

  assign sync_reset = sync_reset_q;
  assign reset_done = reset_done_q;

endmodule
